// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared types for the instruction bus arbiter
package ibex_pkg;

  typedef enum logic {
    REQ_M0 = 1'b0,
    REQ_M1 = 1'b1
  } req_id_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_M0) ? REQ_M1 : REQ_M0;
  endfunction

endpackage

// File: rtl/ibex_instr_arb_id_fifo.sv
// rtl/ibex_instr_arb_id_fifo.sv - FIFO of requester IDs awaiting a memory response
module ibex_instr_arb_id_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth    = 2,
  parameter bit          ResetAll = 1'b0
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  req_id_e push_id_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output req_id_e head_o
);

  localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned     CntW    = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(Depth);

  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  req_id_e         mem [Depth];
  logic            do_push;
  logic            do_pop;

  function automatic logic [PtrW-1:0] incr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count == CntMax);
  assign empty_o = (count == '0);
  assign head_o  = mem[rd_ptr];
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= incr(wr_ptr);
      if (do_pop)  rd_ptr <= incr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (ResetAll && rst_i) begin
      for (int i = 0; i < int'(Depth); i++) mem[i] <= REQ_M0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_id_i;
    end
  end

endmodule

// File: rtl/ibex_instr_bus_arbiter.sv
// rtl/ibex_instr_bus_arbiter.sv - round-robin arbiter sharing one instruction port
// between the prefetch buffer (m0) and the debug/loader port (m1).
module ibex_instr_bus_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          ResetAll       = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,

  output logic        busy_o,
  output logic        resp_orphan_o
);

  arb_state_e state_q, state_d;
  req_id_e    rr_q;
  req_id_e    lock_id_q;
  req_id_e    winner;
  req_id_e    head;
  logic       req_any;
  logic       grant;
  logic       route;
  logic       fifo_full;
  logic       fifo_empty;

  always_comb begin
    state_d = state_q;
    winner  = lock_id_q;
    req_any = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (m0_req_i && m1_req_i) winner = rr_q;
        else if (m1_req_i)        winner = REQ_M1;
        else                      winner = REQ_M0;
        req_any = (m0_req_i | m1_req_i) & ~fifo_full;
        if (req_any && !instr_gnt_i) state_d = ARB_LOCKED;
      end
      ARB_LOCKED: begin
        // The memory side already sees this request; it must not change.
        winner  = lock_id_q;
        req_any = 1'b1;
        if (instr_gnt_i) state_d = ARB_IDLE;
      end
    endcase
  end

  assign instr_req_o   = req_any & ~rst_i;
  assign instr_addr_o  = (winner == REQ_M1) ? m1_addr_i : m0_addr_i;
  assign grant         = instr_req_o & instr_gnt_i;
  assign m0_gnt_o      = grant & (winner == REQ_M0);
  assign m1_gnt_o      = grant & (winner == REQ_M1);

  assign route         = instr_rvalid_i & ~fifo_empty & ~rst_i;
  assign m0_rvalid_o   = route & (head == REQ_M0);
  assign m1_rvalid_o   = route & (head == REQ_M1);
  assign m0_rdata_o    = instr_rdata_i;
  assign m1_rdata_o    = instr_rdata_i;
  assign m0_err_o      = instr_err_i;
  assign m1_err_o      = instr_err_i;
  assign resp_orphan_o = instr_rvalid_i & fifo_empty & ~rst_i;
  assign busy_o        = ~rst_i & (~fifo_empty | m0_req_i | m1_req_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      rr_q    <= REQ_M0;
    end else begin
      state_q <= state_d;
      if (grant) rr_q <= other_req(winner);
    end
  end

  always_ff @(posedge clk_i) begin
    if (ResetAll && rst_i) begin
      lock_id_q <= REQ_M0;
    end else if (state_q == ARB_IDLE) begin
      lock_id_q <= winner;
    end
  end

  ibex_instr_arb_id_fifo #(
    .Depth    (MaxOutstanding),
    .ResetAll (ResetAll)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (grant),
    .push_id_i (winner),
    .pop_i     (instr_rvalid_i & ~rst_i),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (head)
  );

endmodule

// File: tb/tb_ibex_instr_bus_arbiter.sv
// tb/tb_ibex_instr_bus_arbiter.sv - bench for ibex_instr_bus_arbiter
module tb_ibex_instr_bus_arbiter;

  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic rst;
  logic m0_req, m0_gnt, m0_rvalid, m0_err;
  logic m1_req, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_addr, m0_rdata, m1_addr, m1_rdata;
  logic instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic busy, orphan;

  always #5 clk = ~clk;

  ibex_instr_bus_arbiter #(.MaxOutstanding(MAXO), .ResetAll(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr),
    .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr),
    .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .instr_req_o(instr_req), .instr_gnt_i(instr_gnt), .instr_addr_o(instr_addr),
    .instr_rvalid_i(instr_rvalid), .instr_rdata_i(instr_rdata), .instr_err_i(instr_err),
    .busy_o(busy), .resp_orphan_o(orphan)
  );

  int checks = 0;
  int errors = 0;

  // Reference: a queue of outstanding requester IDs plus the favoured requester.
  int mq[$];
  int rr = 0;
  bit locked = 0;
  int lock_id = 0;

  logic s_req, s_g0, s_g1, s_rv0, s_rv1, s_orph;
  logic [31:0] s_addr, s_rd0, s_rd1;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit r0, input bit r1, input logic [31:0] a0,
                      input logic [31:0] a1, input bit g, input bit rv,
                      input logic [31:0] rd, input bit er);
    bit ereq, epop, eorph, ebusy;
    int w, ehead;
    @(negedge clk);
    rst = r; m0_req = r0; m1_req = r1; m0_addr = a0; m1_addr = a1;
    instr_gnt = g; instr_rvalid = rv; instr_rdata = rd; instr_err = er;
    #1;
    w = 0;
    ehead = 0;
    if (r) ereq = 0;
    else if (locked) begin
      ereq = 1; w = lock_id;
    end else if (mq.size() < MAXO && (r0 || r1)) begin
      ereq = 1; w = (r0 && r1) ? rr : (r0 ? 0 : 1);
    end else ereq = 0;
    epop  = !r && rv && mq.size() > 0;
    if (epop) ehead = mq[0];
    eorph = !r && rv && mq.size() == 0;
    ebusy = !r && (mq.size() > 0 || r0 || r1);

    chk1("instr_req", instr_req, ereq);
    if (ereq) chk32("instr_addr", instr_addr, (w == 1) ? a1 : a0);
    chk1("m0_gnt", m0_gnt, ereq && g && w == 0);
    chk1("m1_gnt", m1_gnt, ereq && g && w == 1);
    chk1("m0_rvalid", m0_rvalid, epop && ehead == 0);
    chk1("m1_rvalid", m1_rvalid, epop && ehead == 1);
    chk1("orphan", orphan, eorph);
    chk1("busy", busy, ebusy);
    if (epop && ehead == 0) begin
      chk32("m0_rdata", m0_rdata, rd); chk1("m0_err", m0_err, er);
    end
    if (epop && ehead == 1) begin
      chk32("m1_rdata", m1_rdata, rd); chk1("m1_err", m1_err, er);
    end

    s_req = instr_req; s_g0 = m0_gnt; s_g1 = m1_gnt; s_rv0 = m0_rvalid;
    s_rv1 = m1_rvalid; s_orph = orphan; s_addr = instr_addr;
    s_rd0 = m0_rdata; s_rd1 = m1_rdata;

    @(posedge clk);
    if (r) begin
      mq.delete(); locked = 0; rr = 0;
    end else begin
      if (epop) void'(mq.pop_front());
      if (ereq && g) begin
        mq.push_back(w); rr = 1 - w; locked = 0;
      end else if (ereq) begin
        locked = 1; lock_id = w;
      end
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; m0_req = 0; m1_req = 0; m0_addr = 0; m1_addr = 0;
    instr_gnt = 0; instr_rvalid = 0; instr_rdata = 0; instr_err = 0;

    do_reset();
    chk1("rst_req", s_req, 1'b0);
    chk1("rst_orphan", s_orph, 1'b0);

    // Single m0 fetch with immediate grant, response next cycle.
    step(0, 1, 0, 32'h100, 0, 1, 0, 0, 0);
    chk1("t35_gnt", s_g0, 1'b1);
    chk32("t35_addr", s_addr, 32'h100);
    step(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
    chk1("t35_rv0", s_rv0, 1'b1);
    chk32("t35_rd0", s_rd0, 32'hDEADBEEF);
    chk1("t35_rv1", s_rv1, 1'b0);

    // Both requesting continuously: grants and responses alternate.
    do_reset();
    step(0, 1, 1, 32'h10, 32'h20, 1, 0, 0, 0);
    chk1("t36_g0_a", s_g0, 1'b1);
    step(0, 1, 1, 32'h10, 32'h20, 1, 1, 32'h1, 0);
    chk1("t36_g1_a", s_g1, 1'b1);  chk1("t36_rv0_a", s_rv0, 1'b1);
    step(0, 1, 1, 32'h10, 32'h20, 1, 1, 32'h2, 0);
    chk1("t36_g0_b", s_g0, 1'b1);  chk1("t36_rv1_a", s_rv1, 1'b1);
    step(0, 1, 1, 32'h10, 32'h20, 1, 1, 32'h3, 0);
    chk1("t36_g1_b", s_g1, 1'b1);  chk1("t36_rv0_b", s_rv0, 1'b1);
    step(0, 0, 0, 0, 0, 0, 1, 32'h4, 1);
    chk1("t36_rv1_b", s_rv1, 1'b1);

    // Stalled grant keeps m0 locked on the bus.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 32'h200, 32'h300, 0, 0, 0, 0);
      chk32("t37_addr", s_addr, 32'h200);
      chk1("t37_g1", s_g1, 1'b0);
    end
    step(0, 1, 1, 32'h200, 32'h300, 1, 0, 0, 0);
    chk32("t37_addr4", s_addr, 32'h200);
    chk1("t37_g0", s_g0, 1'b1);
    step(0, 0, 1, 32'h200, 32'h300, 1, 0, 0, 0);
    chk1("t37_g1_late", s_g1, 1'b1);
    chk32("t37_addr_m1", s_addr, 32'h300);

    // Full FIFO blocks arbitration; simultaneous push/pop keeps order.
    do_reset();
    step(0, 1, 0, 32'h40, 0, 1, 0, 0, 0);
    step(0, 1, 0, 32'h44, 0, 1, 0, 0, 0);
    step(0, 1, 1, 32'h48, 32'h80, 1, 0, 0, 0);
    chk1("t38_req_full", s_req, 1'b0);
    step(0, 1, 1, 32'h48, 32'h80, 1, 1, 32'h11, 0);
    chk1("t38_req_full2", s_req, 1'b0);  chk1("t38_rv0", s_rv0, 1'b1);
    step(0, 1, 1, 32'h48, 32'h80, 1, 0, 0, 0);
    chk1("t38_resume", s_req, 1'b1);  chk1("t38_g1", s_g1, 1'b1);
    step(0, 1, 0, 32'h4C, 0, 1, 1, 32'h22, 0);
    chk1("t39_req_full", s_req, 1'b0);  chk1("t39_rv0", s_rv0, 1'b1);
    step(0, 1, 0, 32'h4C, 0, 1, 1, 32'h33, 0);
    chk1("t39_g0", s_g0, 1'b1);  chk1("t39_rv1", s_rv1, 1'b1);
    chk32("t39_rd1", s_rd1, 32'h33);
    step(0, 0, 1, 0, 32'h84, 1, 0, 0, 0);
    chk1("t39_g1", s_g1, 1'b1);
    step(0, 1, 1, 32'h50, 32'h88, 1, 0, 0, 0);
    chk1("t39_full", s_req, 1'b0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h55, 0);
    chk1("t39_order0", s_rv0, 1'b1);
    step(0, 0, 0, 0, 0, 0, 1, 32'h66, 0);
    chk1("t39_order1", s_rv1, 1'b1);

    // Orphan response on empty FIFO.
    do_reset();
    step(0, 0, 0, 0, 0, 0, 1, 32'h77, 0);
    chk1("t40_orph", s_orph, 1'b1);
    chk1("t40_rv0", s_rv0, 1'b0);  chk1("t40_rv1", s_rv1, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk1("t40_orph_end", s_orph, 1'b0);

    // Reset discards outstanding IDs.
    step(0, 1, 0, 32'h90, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 32'h94, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, 32'h99, 0);
      chk1("t41_orph", s_orph, 1'b1);
      chk1("t41_rv0", s_rv0, 1'b0);  chk1("t41_rv1", s_rv1, 1'b0);
    end

    // Randomized traffic against the reference queue.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0, 1'($urandom), 1'($urandom),
           $urandom, $urandom, 1'($urandom), $urandom_range(0, 2) == 0,
           $urandom, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
